// File: rtl/or_input_packer.sv
// Packs a stream of BIT-wide words into one NUMBER_INPUT-lane frame for a downstream OR stage.
// Short frames (closed by in_last) leave the remaining lanes at zero so the OR result is unaffected.
module or_input_packer #(
    parameter int BIT          = 19,
    parameter int NUMBER_INPUT = 8
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 in_valid,
    input  logic [BIT-1:0]                       in_data,
    input  logic                                 in_last,
    output logic                                 in_ready,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [NUMBER_INPUT*BIT-1:0]          IN,
    output logic [$clog2(NUMBER_INPUT+1)-1:0]    pack_cnt
);

    localparam int CW = $clog2(NUMBER_INPUT + 1);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t                      state;
    state_t                      state_nx;
    logic [NUMBER_INPUT*BIT-1:0] lanes_nx;
    logic [CW-1:0]               cnt_nx;
    logic                        accept;

    assign accept = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FILL;
            IN        <= '0;
            pack_cnt  <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nx;
            IN        <= lanes_nx;
            pack_cnt  <= cnt_nx;
            // Handshake outputs are registered from the next state, so they track the state flop exactly.
            in_ready  <= (state_nx == FILL);
            out_valid <= (state_nx == HOLD);
        end
    end

    always_comb begin
        state_nx = state;
        lanes_nx = IN;
        cnt_nx   = pack_cnt;
        case (state)
            FILL: begin
                if (accept) begin
                    for (int unsigned j = 0; j < NUMBER_INPUT; j++) begin
                        if (pack_cnt == CW'(j)) begin
                            lanes_nx[j*BIT +: BIT] = in_data;
                        end
                    end
                    cnt_nx = pack_cnt + CW'(1);
                    if ((pack_cnt == CW'(NUMBER_INPUT - 1)) || in_last) begin
                        state_nx = HOLD;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_nx = FILL;
                    lanes_nx = '0;
                    cnt_nx   = '0;
                end
            end
            default: begin
                state_nx = FILL;
                lanes_nx = '0;
                cnt_nx   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_or_input_packer.sv
// Directed vector table plus hand-written backpressure, reset and random scoreboard sequences for or_input_packer.
module tb_or_input_packer;

    localparam int W  = 19;
    localparam int N  = 8;
    localparam int CW = $clog2(N + 1);
    localparam int NF = 100;

    typedef logic [N-1:0][W-1:0] lanes_t;

    typedef struct {
        logic          v;
        logic [W-1:0]  d;
        logic          l;
        logic          ordy;
        logic          e_rdy;
        logic          e_ov;
        logic [CW-1:0] e_cnt;
        lanes_t        e_lanes;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [W-1:0]  in_data = '0;
    logic          in_last = 1'b0;
    logic          in_ready;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [N*W-1:0] frame_bus;
    logic [CW-1:0] pack_cnt;

    int tests = 0;
    int fails = 0;

    vec_t   vecs[$];
    lanes_t acc;
    logic [W-1:0] rw[N*NF];

    or_input_packer #(.BIT(W), .NUMBER_INPUT(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .IN        (frame_bus),
        .pack_cnt  (pack_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [N*W-1:0] act, input logic [N*W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic v, input logic [W-1:0] d, input logic l, input logic ordy,
                       input logic e_rdy, input logic e_ov, input int e_cnt, input lanes_t e_lanes);
        vec_t t;
        t.v = v; t.d = d; t.l = l; t.ordy = ordy;
        t.e_rdy = e_rdy; t.e_ov = e_ov; t.e_cnt = CW'(e_cnt); t.e_lanes = e_lanes;
        vecs.push_back(t);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Full frame of one-hot words; out_ready high during fill must be ignored.
        acc = '0;
        for (int k = 0; k < N; k++) begin
            acc[k] = W'(1) << k;
            add(1'b1, W'(1) << k, 1'b0, 1'b1, k < N-1, k == N-1, k+1, acc);
        end
        add(1'b0, 'x, 1'b0, 1'b1, 1'b1, 1'b0, 0, '0);
        // Short frame, in_last without in_valid ignored, hold then release with a pending word.
        acc = '0;
        add(1'b0, 'x, 1'b1, 1'b0, 1'b1, 1'b0, 0, acc);
        acc[0] = 19'h7FFFF;
        add(1'b1, 19'h7FFFF, 1'b0, 1'b0, 1'b1, 1'b0, 1, acc);
        add(1'b0, 'x, 1'b1, 1'b0, 1'b1, 1'b0, 1, acc);
        acc[1] = 19'h00001;
        add(1'b1, 19'h00001, 1'b0, 1'b0, 1'b1, 1'b0, 2, acc);
        acc[2] = 19'h00010;
        add(1'b1, 19'h00010, 1'b1, 1'b0, 1'b0, 1'b1, 3, acc);
        add(1'b1, 19'h00055, 1'b0, 1'b0, 1'b0, 1'b1, 3, acc);
        add(1'b1, 19'h00055, 1'b1, 1'b1, 1'b1, 1'b0, 0, '0);
        // Bubbled frame with in_last on the 8th word: same result as the gapless frame.
        acc = '0;
        for (int k = 0; k < N; k++) begin
            acc[k] = W'(1) << k;
            add(1'b1, W'(1) << k, k == N-1, 1'b0, k < N-1, k == N-1, k+1, acc);
            if (k < N-1) add(1'b0, 'x, 1'b1, 1'b0, 1'b1, 1'b0, k+1, acc);
        end
        add(1'b0, 'x, 1'b0, 1'b0, 1'b0, 1'b1, N, acc);
        add(1'b0, 'x, 1'b0, 1'b1, 1'b1, 1'b0, 0, '0);

        // Reset state, checked while reset is still asserted.
        repeat (2) @(negedge clk);
        chk("reset out_valid", out_valid, 0);
        chk("reset pack_cnt", pack_cnt, 0);
        chk("reset IN", frame_bus, 0);
        rst_n = 1'b1;
        #1;
        chk("reset in_ready", in_ready, 1);

        foreach (vecs[i]) begin
            in_valid = vecs[i].v; in_data = vecs[i].d; in_last = vecs[i].l; out_ready = vecs[i].ordy;
            tick();
            chk($sformatf("vec%0d in_ready", i), in_ready, vecs[i].e_rdy);
            chk($sformatf("vec%0d out_valid", i), out_valid, vecs[i].e_ov);
            chk($sformatf("vec%0d pack_cnt", i), pack_cnt, vecs[i].e_cnt);
            chk($sformatf("vec%0d IN", i), frame_bus, vecs[i].e_lanes);
            @(negedge clk);
        end

        // Backpressure: frame held for 10 cycles while upstream keeps offering a word.
        acc = '0;
        for (int k = 0; k < N; k++) begin
            in_valid = 1'b1; in_data = W'('h100 + k); in_last = 1'b0; out_ready = 1'b0;
            acc[k] = W'('h100 + k);
            tick();
            @(negedge clk);
        end
        in_data = 19'h2AAAA;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("bp%0d in_ready", i), in_ready, 0);
            chk($sformatf("bp%0d out_valid", i), out_valid, 1);
            chk($sformatf("bp%0d IN", i), frame_bus, acc);
            @(negedge clk);
        end
        out_ready = 1'b1;
        tick();
        chk("bp release out_valid", out_valid, 0);
        chk("bp release pack_cnt", pack_cnt, 0);
        chk("bp release IN", frame_bus, 0);
        @(negedge clk);
        out_ready = 1'b0;
        tick();
        acc = '0;
        acc[0] = 19'h2AAAA;
        chk("bp held word pack_cnt", pack_cnt, 1);
        chk("bp held word IN", frame_bus, acc);
        @(negedge clk);

        // Reset mid-frame after 5 words, then a clean frame.
        for (int k = 1; k < 5; k++) begin
            in_data = W'('h300 + k);
            tick();
            @(negedge clk);
        end
        chk("pre-reset pack_cnt", pack_cnt, 5);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midreset IN", frame_bus, 0);
        chk("midreset pack_cnt", pack_cnt, 0);
        chk("midreset out_valid", out_valid, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        acc = '0;
        for (int k = 0; k < N; k++) begin
            in_valid = 1'b1; in_data = W'('h400 + k);
            acc[k] = W'('h400 + k);
            tick();
            if (k < N-1) chk($sformatf("postreset%0d out_valid", k), out_valid, 0);
            @(negedge clk);
        end
        chk("postreset frame IN", frame_bus, acc);
        chk("postreset frame pack_cnt", pack_cnt, N);
        chk("postreset frame out_valid", out_valid, 1);
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        chk("postreset drain out_valid", out_valid, 0);
        @(negedge clk);

        // Random frames against a scoreboard of the words sent.
        for (int i = 0; i < N*NF; i++) rw[i] = W'($urandom);
        begin
            int widx = 0;
            int fidx = 0;
            int cycles = 0;
            lanes_t ex;
            while (fidx < NF && cycles < 20000) begin
                in_valid = (widx < N*NF) && ($urandom_range(3) != 0);
                in_data = in_valid ? rw[widx] : 'x;
                in_last = 1'b0;
                out_ready = 1'($urandom_range(1));
                #1;
                if (out_valid && out_ready) begin
                    for (int j = 0; j < N; j++) ex[j] = rw[fidx*N + j];
                    chk($sformatf("rand frame%0d IN", fidx), frame_bus, ex);
                    chk($sformatf("rand frame%0d pack_cnt", fidx), pack_cnt, N);
                    fidx++;
                end
                if (in_valid && in_ready) widx++;
                @(posedge clk);
                @(negedge clk);
                cycles++;
            end
            chk("rand frames received", fidx, NF);
            chk("rand words accepted", widx, N*NF);
            in_valid = 1'b0; out_ready = 1'b0;
            tick();
            chk("rand no extra frame", out_valid, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
